pin_entry_collector: RTL and testbench

Sequential front end that sits directly upstream of the combinational 16-bit PIN comparator (`Pin[15:0]` → `Unlock`). It assembles four hex keypad digits into a 16-bit PIN and presents it to the comparator for one check cycle. It then registers the comparator's verdict, counts consecutive failed attempts and enforces a timed lockout after too many failures.

---
 rtl/pin_lock_pkg.sv | 17 +
 rtl/lockout_timer.sv | 27 ++
 rtl/pin_entry_collector.sv | 124 ++++++++++++
 tb/tb_pin_entry_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pin_lock_pkg.sv
// Shared types and constants for the PIN entry collector.
package pin_lock_pkg;

    localparam int unsigned PIN_W               = 16;
    localparam int unsigned DIGIT_W             = 4;
    localparam int unsigned NUM_DIGITS          = 4;
    localparam int unsigned COUNT_W             = 3;
    localparam int unsigned DEFAULT_MAX_FAILS   = 3;
    localparam int unsigned DEFAULT_LOCK_CYCLES = 1000;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        LOCKOUT = 2'd2
    } pin_state_t;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; done flags the final count of a lockout period.
module lockout_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/pin_entry_collector.sv
// Collects four keypad digits, presents them for one check cycle, tracks
// consecutive failures and enforces a timed lockout.
module pin_entry_collector
    import pin_lock_pkg::*;
#(
    parameter int unsigned MAX_FAILS   = DEFAULT_MAX_FAILS,
    parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_clear,
    output logic [PIN_W-1:0]   pin,
    output logic               pin_valid,
    input  logic               unlock_in,
    output logic               unlock_ok,
    output logic               unlock_fail,
    output logic               locked_out,
    output logic [COUNT_W-1:0] digit_count
);

    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned TIMER_W = $clog2(LOCK_CYCLES + 1);

    pin_state_t         state, state_d;
    logic [PIN_W-1:0]   pin_d;
    logic [COUNT_W-1:0] count_d;
    logic [FAIL_W-1:0]  fail_cnt, fail_d;
    logic               valid_d, ok_d, bad_d, locked_d;
    logic               timer_load, timer_done;

    lockout_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(LOCK_CYCLES)),
        .done     (timer_done)
    );

    // State, entry and verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            pin         <= '0;
            digit_count <= '0;
            fail_cnt    <= '0;
            pin_valid   <= 1'b0;
            unlock_ok   <= 1'b0;
            unlock_fail <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            state       <= state_d;
            pin         <= pin_d;
            digit_count <= count_d;
            fail_cnt    <= fail_d;
            pin_valid   <= valid_d;
            unlock_ok   <= ok_d;
            unlock_fail <= bad_d;
            locked_out  <= locked_d;
        end
    end

    // Next-state and next-output logic; clear beats a same-cycle digit.
    always_comb begin
        state_d    = state;
        pin_d      = pin;
        count_d    = digit_count;
        fail_d     = fail_cnt;
        valid_d    = 1'b0;
        ok_d       = 1'b0;
        bad_d      = 1'b0;
        locked_d   = 1'b0;
        timer_load = 1'b0;
        unique case (state)
            COLLECT: begin
                if (key_clear) begin
                    pin_d   = '0;
                    count_d = '0;
                end else if (key_valid) begin
                    pin_d   = {pin[PIN_W-DIGIT_W-1:0], key_code};
                    count_d = digit_count + COUNT_W'(1);
                    if (digit_count == COUNT_W'(NUM_DIGITS - 1)) begin
                        state_d = CHECK;
                        valid_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                pin_d   = '0;
                count_d = '0;
                state_d = COLLECT;
                if (unlock_in) begin
                    ok_d   = 1'b1;
                    fail_d = '0;
                end else begin
                    bad_d = 1'b1;
                    if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                        fail_d     = FAIL_W'(MAX_FAILS);
                        timer_load = 1'b1;
                        locked_d   = 1'b1;
                        state_d    = LOCKOUT;
                    end else begin
                        fail_d = fail_cnt + FAIL_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                locked_d = 1'b1;
                if (timer_done) begin
                    locked_d = 1'b0;
                    fail_d   = '0;
                    state_d  = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector with a modelled comparator.
module tb_pin_entry_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_clear = 1'b0;
    logic [15:0] pin;
    logic        pin_valid;
    logic        unlock_in;
    logic        unlock_ok;
    logic        unlock_fail;
    logic        locked_out;
    logic [2:0]  digit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Comparator model: correct PIN is 0xABC7.
    assign unlock_in = pin_valid && (pin == 16'hABC7);

    pin_entry_collector #(
        .MAX_FAILS   (3),
        .LOCK_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_clear   (key_clear),
        .pin         (pin),
        .pin_valid   (pin_valid),
        .unlock_in   (unlock_in),
        .unlock_ok   (unlock_ok),
        .unlock_fail (unlock_fail),
        .locked_out  (locked_out),
        .digit_count (digit_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        tick();
        key_valid = 1'b0;
    endtask

    // Four digits then the check cycle; returns just after the verdict edge.
    task automatic enter(input logic [15:0] p);
        key(p[15:12]);
        key(p[11:8]);
        key(p[7:4]);
        key(p[3:0]);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;

        // Reset values
        repeat (3) tick();
        check("rst_pin", 32'(pin), 32'h0);
        check("rst_valid", 32'(pin_valid), 32'h0);
        check("rst_ok", 32'(unlock_ok), 32'h0);
        check("rst_fail", 32'(unlock_fail), 32'h0);
        check("rst_locked", 32'(locked_out), 32'h0);
        check("rst_count", 32'(digit_count), 32'h0);
        rst = 1'b0;
        tick();

        // Correct PIN A,B,C,7
        key(4'hA);
        check("t1_cnt1", 32'(digit_count), 32'd1);
        check("t1_pin1", 32'(pin), 32'h000A);
        key(4'hB);
        key(4'hC);
        key(4'h7);
        check("t1_pin", 32'(pin), 32'hABC7);
        check("t1_valid", 32'(pin_valid), 32'h1);
        check("t1_cnt4", 32'(digit_count), 32'd4);
        check("t1_ok_early", 32'(unlock_ok), 32'h0);
        tick();
        check("t1_valid_off", 32'(pin_valid), 32'h0);
        check("t1_ok", 32'(unlock_ok), 32'h1);
        check("t1_nofail", 32'(unlock_fail), 32'h0);
        check("t1_pin_clr", 32'(pin), 32'h0);
        check("t1_cnt_clr", 32'(digit_count), 32'd0);
        check("t1_failcnt", 32'(dut.fail_cnt), 32'd0);
        tick();
        check("t1_ok_pulse", 32'(unlock_ok), 32'h0);

        // Three wrong entries, back to back, then lockout
        enter(16'h1234);
        check("t2_fail1", 32'(unlock_fail), 32'h1);
        check("t2_failcnt1", 32'(dut.fail_cnt), 32'd1);
        enter(16'h1234);
        check("t2_fail2", 32'(unlock_fail), 32'h1);
        check("t2_lock2", 32'(locked_out), 32'h0);
        enter(16'h1234);
        check("t2_fail3", 32'(unlock_fail), 32'h1);
        check("t2_lock3", 32'(locked_out), 32'h1);
        cnt = 1;
        guard = 0;
        while (locked_out && guard < 20) begin
            key_valid = 1'b1;
            key_code  = 4'h5;
            tick();
            guard++;
            if (locked_out) cnt++;
        end
        key_valid = 1'b0;
        check("t2_lock_len", 32'(cnt), 32'd8);
        check("t2_lock_keys", 32'(digit_count), 32'd0);
        check("t2_failcnt_rst", 32'(dut.fail_cnt), 32'd0);
        key(4'h1);
        check("t2_first_key", 32'(digit_count), 32'd1);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("t2_clear", 32'(digit_count), 32'd0);

        // Partial entry cleared, then correct PIN
        key(4'hA);
        key(4'hB);
        check("t3_cnt2", 32'(digit_count), 32'd2);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("t3_cnt_clr", 32'(digit_count), 32'd0);
        check("t3_pin_clr", 32'(pin), 32'h0);
        enter(16'hABC7);
        check("t3_ok", 32'(unlock_ok), 32'h1);
        check("t3_nofail", 32'(unlock_fail), 32'h0);

        // Clear and digit in the same cycle
        key(4'h1);
        key(4'h2);
        key_valid = 1'b1;
        key_clear = 1'b1;
        key_code  = 4'h9;
        tick();
        key_valid = 1'b0;
        key_clear = 1'b0;
        check("t4_cnt", 32'(digit_count), 32'd0);
        check("t4_pin", 32'(pin), 32'h0);

        // Success resets the failure count
        enter(16'h1234);
        enter(16'h1234);
        check("t5_failcnt2", 32'(dut.fail_cnt), 32'd2);
        enter(16'hABC7);
        check("t5_ok", 32'(unlock_ok), 32'h1);
        check("t5_failcnt0", 32'(dut.fail_cnt), 32'd0);
        enter(16'h1234);
        check("t5_lock_a", 32'(locked_out), 32'h0);
        enter(16'h1234);
        check("t5_lock_b", 32'(locked_out), 32'h0);
        enter(16'h1234);
        check("t5_lock_c", 32'(locked_out), 32'h1);

        // Reset in the middle of lockout
        repeat (3) tick();
        check("t6_still_locked", 32'(locked_out), 32'h1);
        rst = 1'b1;
        tick();
        check("t6_locked", 32'(locked_out), 32'h0);
        check("t6_pin", 32'(pin), 32'h0);
        check("t6_valid", 32'(pin_valid), 32'h0);
        check("t6_ok", 32'(unlock_ok), 32'h0);
        check("t6_fail", 32'(unlock_fail), 32'h0);
        check("t6_cnt", 32'(digit_count), 32'd0);
        check("t6_failcnt", 32'(dut.fail_cnt), 32'd0);
        rst = 1'b0;
        key(4'hA);
        check("t6_key_cnt", 32'(digit_count), 32'd1);
        check("t6_key_pin", 32'(pin), 32'h000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
